imem_arbiter: RTL and testbench

//  Shares the single instruction memory between two requesters: CPU fetch (F, read-only)
//  and program loader/debug port (L, read/write). One access per cycle.

---
 rtl/imem_arbiter.sv | 137 +++++++++++++
 tb/tb_imem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-port instruction memory arbiter: CPU fetch vs loader/debug.
// Combinational grant, registered read return, bounded-burst fairness.
module imem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_stall,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          f_rvalid_q, f_rvalid_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] l_rdata_q, l_rdata_d;
  logic          under_max;
  logic          l_rd_gnt;

  assign under_max = (cnt_q < CMAX);

  // Contention: stay with the owner until its burst is used up.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    unique case ({f_req, l_req})
      2'b11: begin
        unique case (owner_q)
          FETCH:   begin
            f_gnt = under_max;
            l_gnt = ~under_max;
          end
          LOAD:    begin
            l_gnt = under_max;
            f_gnt = ~under_max;
          end
          default: l_gnt = 1'b1;
        endcase
      end
      2'b10:   f_gnt = 1'b1;
      2'b01:   l_gnt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    owner_d = IDLE;
    cnt_d   = '0;
    if (f_gnt) begin
      owner_d = FETCH;
      if (owner_q == FETCH)
        cnt_d = under_max ? cnt_q + CW'(1) : cnt_q;
      else
        cnt_d = CW'(1);
    end else if (l_gnt) begin
      owner_d = LOAD;
      if (owner_q == LOAD)
        cnt_d = under_max ? cnt_q + CW'(1) : cnt_q;
      else
        cnt_d = CW'(1);
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      mem_we    = l_we;
    end
  end

  assign l_rd_gnt = l_gnt & ~l_we;

  always_comb begin
    f_rvalid_d = f_gnt;
    l_rvalid_d = l_rd_gnt;
    f_rdata_d  = f_gnt ? mem_rdata : f_rdata_q;
    l_rdata_d  = l_rd_gnt ? mem_rdata : l_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= IDLE;
      cnt_q      <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign f_stall  = f_req & ~f_gnt;
  assign f_rvalid = f_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign l_rvalid = l_rvalid_q;
  assign l_rdata  = l_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table,
// burst/reset sequences and a randomized model run.
module tb_imem_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, l_req, l_we;
  logic [7:0]  f_addr, l_addr;
  logic [31:0] l_wdata;
  logic        f_gnt, f_stall, f_rvalid;
  logic [31:0] f_rdata;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [256] = '{default: 32'h0};

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  imem_arbiter #(.AW(8), .DW(32), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_stall(f_stall), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .l_rdata(l_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic fr, input logic [7:0] fa,
                       input logic lr, input logic lw,
                       input logic [7:0] la, input logic [31:0] ld);
    f_req = fr; f_addr = fa;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
  endtask

  typedef struct {
    logic        fr;
    logic [7:0]  fa;
    logic        lr;
    logic        lw;
    logic [7:0]  la;
    logic [31:0] ld;
    logic        fg;
    logic        lg;
    logic        st;
    logic        mwe;
    logic [7:0]  maddr;
    logic        frv;
    logic [31:0] frd;
    logic        lrv;
    logic [31:0] lrd;
  } vec_t;

  vec_t tv[9];

  // model state for the random run
  int          m_owner;
  int          m_cnt;
  logic        m_frv, m_lrv;
  logic [31:0] m_frd, m_lrd;
  logic [31:0] ref_mem [256];
  int          f_wait, l_wait;
  logic        ef, el;
  logic        burst_l [12];

  initial begin
    // reg values are those produced by the previous row
    tv[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 32'h8C020004,
              1'b0, 1'b1, 1'b0, 1'b1, 8'h05,
              1'b0, 32'h0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 8'h05,
              1'b0, 32'h0, 1'b0, 32'h0};
    tv[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF,
              1'b0, 1'b1, 1'b0, 1'b1, 8'h10,
              1'b1, 32'h8C020004, 1'b0, 32'h0};
    tv[3] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 8'h10,
              1'b0, 32'h8C020004, 1'b0, 32'h0};
    tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 32'h0,
              1'b0, 1'b1, 1'b0, 1'b0, 8'h05,
              1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
              1'b0, 32'hDEADBEEF, 1'b1, 32'h8C020004};
    tv[6] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 32'h1,
              1'b0, 1'b1, 1'b1, 1'b1, 8'h03,
              1'b0, 32'hDEADBEEF, 1'b0, 32'h8C020004};
    tv[7] = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 32'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 8'h03,
              1'b0, 32'hDEADBEEF, 1'b0, 32'h8C020004};
    tv[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
              1'b1, 32'h1, 1'b0, 32'h8C020004};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst f_rvalid", {31'b0, f_rvalid}, 0);
    chk("rst l_rvalid", {31'b0, l_rvalid}, 0);
    chk("rst f_rdata", f_rdata, 0);
    chk("rst l_rdata", l_rdata, 0);
    chk("rst mem_we", {31'b0, mem_we}, 0);
    #2 reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(tv[i].fr, tv[i].fa, tv[i].lr, tv[i].lw,
            tv[i].la, tv[i].ld);
      @(negedge clk);
      chk($sformatf("v%0d f_gnt", i), {31'b0, f_gnt}, {31'b0, tv[i].fg});
      chk($sformatf("v%0d l_gnt", i), {31'b0, l_gnt}, {31'b0, tv[i].lg});
      chk($sformatf("v%0d f_stall", i), {31'b0, f_stall}, {31'b0, tv[i].st});
      chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, tv[i].mwe});
      chk($sformatf("v%0d mem_addr", i), {24'b0, mem_addr}, {24'b0, tv[i].maddr});
      chk($sformatf("v%0d f_rvalid", i), {31'b0, f_rvalid}, {31'b0, tv[i].frv});
      chk($sformatf("v%0d f_rdata", i), f_rdata, tv[i].frd);
      chk($sformatf("v%0d l_rvalid", i), {31'b0, l_rvalid}, {31'b0, tv[i].lrv});
      chk($sformatf("v%0d l_rdata", i), l_rdata, tv[i].lrd);
    end

    // both requesting from IDLE: L L L L F F F F L L L L
    for (int i = 0; i < 12; i++) burst_l[i] = (i < 4) || (i >= 8);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(1, 8'h05, 1, 0, 8'h10, 0);
      @(negedge clk);
      chk($sformatf("burst%0d l_gnt", i), {31'b0, l_gnt}, {31'b0, burst_l[i]});
      chk($sformatf("burst%0d f_gnt", i), {31'b0, f_gnt}, {31'b0, !burst_l[i]});
      chk($sformatf("burst%0d f_stall", i), {31'b0, f_stall}, {31'b0, burst_l[i]});
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("burst l_rdata", l_rdata, 32'hDEADBEEF);

    // L read granted, then reset pulled before the edge
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 8'h07, 0);
    @(negedge clk);
    chk("rstmid l_gnt", {31'b0, l_gnt}, 1);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rstmid l_rvalid", {31'b0, l_rvalid}, 0);
    chk("rstmid l_rdata", l_rdata, 0);
    chk("rstmid f_rdata", f_rdata, 0);
    #2 reset = 1'b1;
    drive(1, 8'h05, 0, 0, 0, 0);
    #1;
    chk("post-rst f_gnt", {31'b0, f_gnt}, 1);
    chk("post-rst f_stall", {31'b0, f_stall}, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("post-rst f_rvalid", {31'b0, f_rvalid}, 1);
    chk("post-rst f_rdata", f_rdata, 32'h8C020004);

    // randomized run against a reference model, addresses 0x40..0x4F
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
    m_owner = 0; m_cnt = 0;
    m_frv = 0; m_lrv = 0; m_frd = 0; m_lrd = 0;
    f_wait = 0; l_wait = 0;
    ef = 0; el = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (!(f_req && !ef)) begin
        f_req  = ($urandom_range(0, 3) != 0);
        f_addr = 8'h40 + 8'($urandom_range(0, 15));
      end
      if (!(l_req && !el)) begin
        l_req   = ($urandom_range(0, 2) != 0);
        l_we    = $urandom_range(0, 1) == 1;
        l_addr  = 8'h40 + 8'($urandom_range(0, 15));
        l_wdata = $urandom;
      end
      @(negedge clk);
      ef = 0; el = 0;
      if (f_req && l_req) begin
        if (m_owner == 1 && m_cnt < MB) ef = 1;
        else if (m_owner == 2 && m_cnt < MB) el = 1;
        else if (m_owner == 1) el = 1;
        else if (m_owner == 2) ef = 1;
        else el = 1;
      end else begin
        ef = f_req;
        el = l_req;
      end
      chk("rnd f_gnt", {31'b0, f_gnt}, {31'b0, ef});
      chk("rnd l_gnt", {31'b0, l_gnt}, {31'b0, el});
      chk("rnd one gnt", {31'b0, f_gnt & l_gnt}, 0);
      chk("rnd mem_we", {31'b0, mem_we}, {31'b0, el & l_we});
      chk("rnd f_rvalid", {31'b0, f_rvalid}, {31'b0, m_frv});
      chk("rnd l_rvalid", {31'b0, l_rvalid}, {31'b0, m_lrv});
      if (m_frv) chk("rnd f_rdata", f_rdata, m_frd);
      if (m_lrv) chk("rnd l_rdata", l_rdata, m_lrd);
      if (ef) chk("rnd mem_addr f", {24'b0, mem_addr}, {24'b0, f_addr});
      if (el) chk("rnd mem_addr l", {24'b0, mem_addr}, {24'b0, l_addr});

      if (f_req && !ef) f_wait++;
      else f_wait = 0;
      if (l_req && !el) l_wait++;
      else l_wait = 0;
      if (f_wait > MB) chk("rnd f starve", f_wait, MB);
      if (l_wait > MB) chk("rnd l starve", l_wait, MB);

      m_frv = ef;
      m_lrv = el && !l_we;
      if (ef) m_frd = ref_mem[f_addr];
      if (el && !l_we) m_lrd = ref_mem[l_addr];
      if (el && l_we) ref_mem[l_addr] = l_wdata;
      if (ef) begin
        m_cnt = (m_owner == 1) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
        m_owner = 1;
      end else if (el) begin
        m_cnt = (m_owner == 2) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
        m_owner = 2;
      end else begin
        m_owner = 0;
        m_cnt = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
